// File: rtl/buscaminas_tablero.sv
// Parametrised Minesweeper board generator: LFSR mine placement followed by a
// row-major neighbour-count pass, held for a registered random-access read port.
module buscaminas_tablero #(
    parameter int          ROWS  = 8,
    parameter int          COLS  = 8,
    parameter int          MINES = 10,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_matriz,
    input  logic        seed_load,
    input  logic [15:0] seed_val,
    input  logic [3:0]  rd_row,
    input  logic [3:0]  rd_col,
    output logic        rd_mine,
    output logic [3:0]  rd_count,
    output logic        busy,
    output logic        ready,
    output logic [7:0]  mines_placed
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    typedef enum logic [2:0] {IDLE, CLEAR, PLACE, COUNT, READY} state_t;

    state_t          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_next;
    logic            mine_q [ROWS][COLS];
    logic [3:0]      cnt_q  [ROWS][COLS];
    logic [RW-1:0]   cr_q, cand_r;
    logic [CW-1:0]   cc_q, cand_c;
    logic            cand_ok, last_cell, rd_mine_d;
    logic [3:0]      nsum, rd_count_d;

    assign cand_r    = lfsr_q[RW-1:0];
    assign cand_c    = lfsr_q[RW+CW-1:RW];
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign last_cell = (32'(cr_q) == 32'(ROWS - 1)) && (32'(cc_q) == 32'(COLS - 1));
    assign busy      = (state_q == CLEAR) || (state_q == PLACE) || (state_q == COUNT);
    assign ready     = (state_q == READY);

    // Full-board scans with constant indices keep out-of-range addresses harmless.
    always_comb begin
        cand_ok    = 1'b0;
        nsum       = '0;
        rd_mine_d  = 1'b0;
        rd_count_d = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (32'(cand_r) == r && 32'(cand_c) == c && !mine_q[r][c])
                    cand_ok = 1'b1;
                if (mine_q[r][c] && (r + 1 >= 32'(cr_q)) && (r <= 32'(cr_q) + 1) &&
                    (c + 1 >= 32'(cc_q)) && (c <= 32'(cc_q) + 1) &&
                    !(r == 32'(cr_q) && c == 32'(cc_q)))
                    nsum = nsum + 4'd1;
                if (32'(rd_row) == r && 32'(rd_col) == c) begin
                    rd_mine_d  = mine_q[r][c];
                    rd_count_d = cnt_q[r][c];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, READY: if (enable_matriz) state_d = CLEAR;
            CLEAR:       state_d = PLACE;
            PLACE:       if (mines_placed == 8'(MINES)) state_d = COUNT;
            COUNT:       if (last_cell) state_d = READY;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q       <= SEED;
            mines_placed <= '0;
            cr_q         <= '0;
            cc_q         <= '0;
            rd_mine      <= 1'b0;
            rd_count     <= '0;
            for (int unsigned r = 0; r < ROWS; r++)
                for (int unsigned c = 0; c < COLS; c++) begin
                    mine_q[r][c] <= 1'b0;
                    cnt_q[r][c]  <= '0;
                end
        end else begin
            rd_mine  <= rd_mine_d;
            rd_count <= rd_count_d;
            case (state_q)
                IDLE, READY: begin
                    if (seed_load) lfsr_q <= (seed_val == 16'h0000) ? SEED : seed_val;
                end
                CLEAR: begin
                    mines_placed <= '0;
                    cr_q         <= '0;
                    cc_q         <= '0;
                    for (int unsigned r = 0; r < ROWS; r++)
                        for (int unsigned c = 0; c < COLS; c++) begin
                            mine_q[r][c] <= 1'b0;
                            cnt_q[r][c]  <= '0;
                        end
                end
                PLACE: begin
                    lfsr_q <= lfsr_next;
                    if (mines_placed < 8'(MINES) && cand_ok) begin
                        mine_q[cand_r][cand_c] <= 1'b1;
                        mines_placed           <= mines_placed + 8'd1;
                    end
                end
                COUNT: begin
                    cnt_q[cr_q][cc_q] <= nsum;
                    if (32'(cc_q) == 32'(COLS - 1)) begin
                        cc_q <= '0;
                        cr_q <= cr_q + 1'b1;
                    end else begin
                        cc_q <= cc_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/buscaminas_tablero.md
Name: buscaminas_tablero

Overview:
Parametrised Minesweeper board generator for the Buscaminas game, the successor of the fixed 8x8 board matrix. On request it clears the board, places exactly MINES mines at pseudo-random positions from an internal LFSR, and computes the neighbour-mine count for every cell. It then holds the board for the game/VGA logic, which reads it through a registered random-access port. Board size, mine count and seed are parameters; regeneration is possible without reset.

Parameters:
ROWS, 8, board rows (2..16)
COLS, 8, board columns (2..16)
MINES, 10, mines per board (0..ROWS*COLS-1)
SEED, 16'hACE1, LFSR value loaded at reset; must be non-zero
RW, $clog2(ROWS), row index width (derived, localparam)
CW, $clog2(COLS), column index width (derived, localparam)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable_matriz  input  1  start (re)generation; sampled in IDLE or READY only
seed_load  input  1  load seed_val into LFSR; honoured in IDLE/READY only
seed_val  input  16  new seed; 0 is replaced by SEED
rd_row  input  4  read row index
rd_col  input  4  read column index
rd_mine  output  1  mine flag of addressed cell (1-cycle latency)
rd_count  output  4  neighbour-mine count 0..8 of addressed cell (1-cycle latency)
busy  output  1  high in CLEAR, PLACE, COUNT
ready  output  1  high in READY
mines_placed  output  8  mines placed so far on the current board

Behaviour:
- Reset (clk edge with reset=1), including mid-generation: state=IDLE, all mine bits and counts 0, LFSR=SEED, mines_placed=0, busy=0, ready=0, rd_mine=0, rd_count=0. Reset has priority over every other input.
- Storage: ROWS*COLS mine bits plus ROWS*COLS 4-bit counts in registers.
- LFSR: 16-bit Galois, mask 16'hB400, shift right. Advances one step every PLACE cycle only. Not reloaded by enable_matriz, so successive boards differ. Only reset or seed_load reloads it.
- FSM states are IDLE, CLEAR, PLACE, COUNT and READY.
- IDLE/READY: enable_matriz=1 -> CLEAR next cycle. seed_load in the same cycle is applied first, so the new board uses the new seed. enable_matriz and seed_load are ignored while busy.
- CLEAR (1 cycle): all mine bits and counts set to 0, mines_placed=0 -> PLACE.
- PLACE: each cycle, candidate r = lfsr[RW-1:0], c = lfsr[RW+CW-1:RW].
  - If r<ROWS, c<COLS, the cell has no mine and mines_placed<MINES: set the mine bit and increment mines_placed.
  - Otherwise reject the candidate; no change.
  - The cycle in which mines_placed==MINES is observed at entry -> COUNT. MINES=0 therefore spends exactly 1 cycle in PLACE.
- COUNT: one cell per cycle, row-major from (0,0) to (ROWS-1,COLS-1).
  - count = sum of the 8 neighbour mine bits; out-of-board neighbours contribute 0.
  - Mine cells also store their neighbour count.
  - Takes exactly ROWS*COLS cycles, then -> READY.
- READY: board stable until the next enable_matriz or reset.
- Total generation latency: first busy cycle to first ready cycle = 1 + P + ROWS*COLS, where P is the number of PLACE cycles.
- Read port:
  - rd_mine/rd_count are registered from rd_row/rd_col every cycle in every state.
  - Out-of-range index (rd_row>=ROWS or rd_col>=COLS) returns 0/0.
  - Contents are only meaningful while ready=1.
- busy and ready are never high together. Both are low only in IDLE.

Test Plan:
- Reset and idle: hold reset 2 cycles, release, wait 20 cycles -> ready=0, busy=0. Every read of (0..7,0..7) returns rd_mine=0, rd_count=0.
- Default generation (8x8, MINES=10): 1-cycle enable_matriz pulse -> busy=1 on the next cycle. ready=1 after exactly 1+P+64 busy cycles; mines_placed=10; 10 cells read rd_mine=1. Every rd_count equals a bench neighbour-count model, and the corner counts are at most 3.
- Determinism and seed: reset twice with the same SEED -> identical boards. seed_load with seed_val=16'h1234, then enable -> board differs from the SEED board and is repeatable with the same seed. seed_val=0 -> identical to the SEED board.
- Regeneration and ignored inputs: from READY, pulse enable -> CLEAR zeroes the board, then a new board with exactly 10 mines is generated. enable_matriz and seed_load pulses during PLACE/COUNT -> no effect on state or LFSR.
- Reset mid-operation: assert reset during COUNT at cell 30 -> the next cycle shows IDLE, all cells 0, mines_placed=0. A subsequent enable reproduces the first post-reset board exactly.
- Edge parameters: ROWS=5, COLS=3, MINES=0 -> PLACE lasts 1 cycle, ready after 1+1+15 busy cycles, all counts 0. Reads at rd_row=5 or rd_col=3 return 0/0.
